// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared types, defaults and width helpers for the reset sequencer.
// Imported by rst_sync_chain and rst_seq_ctrl.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    SYNC,
    HOLD,
    REL,
    GAP,
    DONE
  } state_t;

  localparam int DEF_NUM_RST     = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_HOLD_CYCLES = 8;
  localparam int DEF_STAGE_GAP   = 4;

  // Bits needed to hold values 0..max_val
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Bits needed to index n channels, never less than 1
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_sync.sv
// rst_sync_chain: async-assert, sync-deassert reset synchroniser.
// Output rises on the STAGES-th clock edge after rst_n is released.
module rst_sync_chain
  import rst_seq_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync
);

  logic [STAGES-1:0] chain;

  // Shift ones in after release; clear immediately on rst_n low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync = chain[STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: ordered multi-channel reset release with software re-reset.
// Optional macro RST_SEQ_CNT_EN adds the sw_rst_cnt saturating counter port.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_RST     = DEF_NUM_RST,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int STAGE_GAP   = DEF_STAGE_GAP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sw_rst_req,
  input  logic [NUM_RST-1:0] sw_rst_mask,
  output logic [NUM_RST-1:0] rst_n_out,
  output logic               rst_done,
  output logic               busy
`ifdef RST_SEQ_CNT_EN
  ,
  output logic [7:0]         sw_rst_cnt
`endif
);

  localparam int CMAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CW   = cnt_width(CMAX);
  localparam int IW   = idx_width(NUM_RST);

  state_t             state;
  state_t             state_nxt;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      cnt_nxt;
  logic [IW-1:0]      idx;
  logic [IW-1:0]      idx_nxt;
  logic [NUM_RST-1:0] mask;
  logic [NUM_RST-1:0] mask_nxt;
  logic [NUM_RST-1:0] out_nxt;
  logic               done_nxt;
  logic               busy_nxt;
  logic               rst_sync;
  logic               do_rel;
  logic               more;
  logic [IW-1:0]      nxt_idx;
  logic [IW-1:0]      sw_first;

  rst_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .rst_sync (rst_sync)
  );

  // Next active channel above idx; lowest index wins
  always_comb begin
    more    = 1'b0;
    nxt_idx = idx;
    for (int i = NUM_RST - 1; i >= 0; i--) begin
      if (mask[i] && (IW'(i) > idx)) begin
        more    = 1'b1;
        nxt_idx = IW'(i);
      end
    end
  end

  // Lowest channel selected by a software request
  always_comb begin
    sw_first = '0;
    for (int i = NUM_RST - 1; i >= 0; i--) begin
      if (sw_rst_mask[i]) begin
        sw_first = IW'(i);
      end
    end
  end

  // Next-state and output decode; a release is folded into the
  // edge that ends HOLD or GAP so it costs no extra cycle
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    mask_nxt  = mask;
    out_nxt   = rst_n_out;
    done_nxt  = rst_done;
    busy_nxt  = busy;
    do_rel    = 1'b0;
    unique case (state)
      SYNC: begin
        if (rst_sync) begin
          if (HOLD_CYCLES == 1) begin
            do_rel = 1'b1;
          end else begin
            state_nxt = HOLD;
            cnt_nxt   = CW'(1);
          end
        end
      end
      HOLD: begin
        if (cnt == CW'(HOLD_CYCLES - 1)) begin
          do_rel = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      GAP: begin
        if (cnt == CW'(STAGE_GAP)) begin
          do_rel = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE: begin
        if (sw_rst_req && (|sw_rst_mask)) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
          mask_nxt  = sw_rst_mask;
          idx_nxt   = sw_first;
          out_nxt   = rst_n_out & ~sw_rst_mask;
          done_nxt  = 1'b0;
          busy_nxt  = 1'b1;
        end
      end
      default: begin
        do_rel = 1'b1;
      end
    endcase
    if (do_rel) begin
      for (int i = 0; i < NUM_RST; i++) begin
        if (IW'(i) == idx) begin
          out_nxt[i] = 1'b1;
        end
      end
      if (more) begin
        state_nxt = GAP;
        cnt_nxt   = CW'(1);
        idx_nxt   = nxt_idx;
      end else begin
        state_nxt = DONE;
        done_nxt  = 1'b0 | 1'b1;
        busy_nxt  = 1'b0;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SYNC;
      cnt       <= '0;
      idx       <= '0;
      mask      <= '1;
      rst_n_out <= '0;
      rst_done  <= 1'b0;
      busy      <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      mask      <= mask_nxt;
      rst_n_out <= out_nxt;
      rst_done  <= done_nxt;
      busy      <= busy_nxt;
    end
  end

`ifdef RST_SEQ_CNT_EN
  logic sw_seq;

  // Count software sequences reaching DONE, saturating at 255
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_seq     <= 1'b0;
      sw_rst_cnt <= '0;
    end else begin
      if (state == DONE && state_nxt == HOLD) begin
        sw_seq <= 1'b1;
      end
      if (sw_seq && state != DONE && state_nxt == DONE
          && sw_rst_cnt != 8'hFF) begin
        sw_rst_cnt <= sw_rst_cnt + 8'd1;
      end
    end
  end
`endif

endmodule
